signal_inference_ctrl: RTL
==========================

Name: signal_inference_ctrl

Overview:
- Parametrised successor to the frame-grabber user-output signaller.
- Drives UserOutput lines from the HLS inference handshake:
  - busy indication while an inference is in flight;
  - fixed-width stretched result strobe carrying the latched class code.
- Measures start-to-result latency, detects timeouts and counts overlapping starts.
- Sits between the HLS threshold/inference core and the CustomLogic user-output pins.

Parameters:
- CLASS_W, 2, width of Result_class; UserOutput width is 2+CLASS_W.
- PULSE_CYC, 16, cycles the RESULT code is held on UserOutput (>=1).
- TIMEOUT_CYC, 1000000, BUSY cycles before abort (< 2^LAT_W).
- LAT_W, 24, width of latency counter/outputs.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- srst_n  in  1  reset, synchronous, active-low.
- HlsPixTh_tvalid  in  1  inference start event (sampled each cycle).
- Result_vld  in  1  inference result valid (single-cycle or level).
- Result_class  in  CLASS_W  class code, valid with Result_vld.
- UserOutput  out  2+CLASS_W  [1:0] status code, [2+CLASS_W-1:2] latched class.
- busy  out  1  high in BUSY state.
- latency  out  LAT_W  cycles from start to result of last completed inference.
- latency_vld  out  1  one-cycle pulse when latency updates.
- timeout_err  out  1  sticky, set on timeout.
- drop_cnt  out  16  saturating count of starts ignored while BUSY.

Behaviour:
- Reset (srst_n=0 at clk edge) sets everything to zero:
  - state IDLE;
  - UserOutput, busy, latency, latency_vld, timeout_err, drop_cnt;
  - internal counters.
- Reset wins over any simultaneous input. Reset mid-inference aborts the inference with no latency_vld.
- All outputs are registered. UserOutput/busy reflect a state change one cycle after the triggering input edge.
- Status codes on UserOutput[1:0]: IDLE=00, BUSY=01, RESULT=10; 11 is never driven.
- State IDLE:
  - HlsPixTh_tvalid=1 -> BUSY, lat_cnt<=1.
  - Result_vld is ignored in IDLE, including when asserted together with tvalid (start has priority).
- State BUSY: lat_cnt increments each cycle.
  - Result_vld=1 -> RESULT:
    - class bits<=Result_class;
    - latency<=lat_cnt, so a result the cycle after start gives latency=1;
    - latency_vld=1 for one cycle;
    - pulse_cnt<=PULSE_CYC-1.
  - HlsPixTh_tvalid=1 without Result_vld -> drop_cnt+1, saturating at 0xFFFF; stay BUSY.
  - tvalid and Result_vld in the same cycle -> result accepted and the start counted as a drop.
  - lat_cnt==TIMEOUT_CYC with no result -> timeout_err<=1 (sticky until reset), go IDLE, latency unchanged, no latency_vld.
- State RESULT: UserOutput[1:0]=10 and class bits held.
  - pulse_cnt decrements; at 0 -> IDLE. The class bits keep their last value in IDLE.
  - HlsPixTh_tvalid=1 -> BUSY immediately (pulse truncated), lat_cnt<=1.
  - Result_vld is ignored.
- Level-held tvalid: after one inference completes, a still-high tvalid in RESULT restarts it. This matches the existing start-priority semantics.

Optional Feature:
- Macro LATENCY_STATS_EN.
- Defined:
  - adds output port lat_max (LAT_W), reset to 0;
  - on each latency_vld, lat_max<=max(lat_max, new latency);
  - adds output port done_cnt (32), a wrapping count of completed inferences.
- Undefined: neither port nor its logic exists. All other behaviour is identical.

Decomposition:
- Package signal_inference_pkg holds:
  - state enum (ST_IDLE, ST_BUSY, ST_RESULT);
  - UO code constants (UO_IDLE=2'b00, UO_BUSY=2'b01, UO_RESULT=2'b10);
  - DROP_W=16.
- One sub-module, sat_counter (parametrised width, clear/inc/saturate):
  - used for lat_cnt and drop_cnt;
  - lat_cnt instance saturates at all-ones, which is unreachable because TIMEOUT_CYC < 2^LAT_W.

Test Plan:
- Reset then idle: all outputs 0, UserOutput=0000 for 100 cycles with Result_vld pulses applied (ignored).
- tvalid pulse at cycle t, Result_vld+class=2'b11 at t+37:
  - UserOutput=0001 from t+1 to t+37;
  - latency=37, latency_vld=1 at t+38;
  - UserOutput=1110 for 16 cycles, then 1100.
- Three extra tvalid pulses while BUSY, then result -> drop_cnt=3, latency counted from first start.
- TIMEOUT_CYC=50 override, tvalid with no result -> timeout_err=1 and IDLE after 50 BUSY cycles, latency_vld never pulses; error persists until srst_n=0.
- tvalid during RESULT pulse (cycle 5 of 16) -> UserOutput[1:0]=01 next cycle; next result latency measured from the new start.
- srst_n=0 for one cycle mid-BUSY -> all outputs zero next cycle. With LATENCY_STATS_EN: latencies 10, 40, 20 -> lat_max=40, done_cnt=3.

Source files
------------

// File: rtl/signal_inference_pkg.sv
// Shared types and constants for the inference user-output signaller.
package signal_inference_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

    localparam logic [1:0] UO_IDLE   = 2'b00;
    localparam logic [1:0] UO_BUSY   = 2'b01;
    localparam logic [1:0] UO_RESULT = 2'b10;

    localparam int DROP_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clr together with inc loads 1 so a restart counts its own cycle.
// Single-cycle update, synchronous active-low reset, no flow control.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? W'(1) : '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/signal_inference_ctrl.sv
// Inference handshake -> UserOutput status/class strobe, latency, timeout and drop tracking.
// All outputs registered (1 cycle after input); LATENCY_STATS_EN adds lat_max/done_cnt.
module signal_inference_ctrl
    import signal_inference_pkg::*;
#(
    parameter int CLASS_W     = 2,
    parameter int PULSE_CYC   = 16,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int LAT_W       = 24
) (
    input  logic                 clk,
    input  logic                 srst_n,
    input  logic                 HlsPixTh_tvalid,
    input  logic                 Result_vld,
    input  logic [CLASS_W-1:0]   Result_class,
    output logic [2+CLASS_W-1:0] UserOutput,
    output logic                 busy,
    output logic [LAT_W-1:0]     latency,
    output logic                 latency_vld,
    output logic                 timeout_err,
    output logic [DROP_W-1:0]    drop_cnt
`ifdef LATENCY_STATS_EN
    ,
    output logic [LAT_W-1:0]     lat_max,
    output logic [31:0]          done_cnt
`endif
);

    localparam int PULSE_W = $clog2(PULSE_CYC + 1);

    state_e               state_q, state_d;
    logic [PULSE_W-1:0]   pulse_q, pulse_d;
    logic [CLASS_W-1:0]   class_q, class_d;
    logic [1:0]           code_q, code_d;
    logic                 busy_q, busy_d;
    logic [LAT_W-1:0]     latency_q, latency_d;
    logic                 lat_vld_q, lat_vld_d;
    logic                 timeout_q, timeout_d;

    logic [LAT_W-1:0]     lat_cnt;
    logic                 lat_clr, lat_inc, drop_inc;

    // lat_cnt never saturates: TIMEOUT_CYC stays below 2^LAT_W.
    sat_counter #(.W(LAT_W)) u_lat_cnt (
        .clk    (clk),
        .srst_n (srst_n),
        .clr    (lat_clr),
        .inc    (lat_inc),
        .cnt    (lat_cnt)
    );

    sat_counter #(.W(DROP_W)) u_drop_cnt (
        .clk    (clk),
        .srst_n (srst_n),
        .clr    (1'b0),
        .inc    (drop_inc),
        .cnt    (drop_cnt)
    );

    always_comb begin
        state_d   = state_q;
        pulse_d   = pulse_q;
        class_d   = class_q;
        latency_d = latency_q;
        lat_vld_d = 1'b0;
        timeout_d = timeout_q;
        lat_clr   = 1'b0;
        lat_inc   = 1'b0;
        drop_inc  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (HlsPixTh_tvalid) begin
                    state_d = ST_BUSY;
                    lat_clr = 1'b1;
                    lat_inc = 1'b1;
                end
            end
            ST_BUSY: begin
                lat_inc  = 1'b1;
                drop_inc = HlsPixTh_tvalid;
                if (Result_vld) begin
                    state_d   = ST_RESULT;
                    class_d   = Result_class;
                    latency_d = lat_cnt;
                    lat_vld_d = 1'b1;
                    pulse_d   = PULSE_W'(PULSE_CYC - 1);
                end else if (lat_cnt == LAT_W'(TIMEOUT_CYC)) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
            end
            ST_RESULT: begin
                // A new start truncates the strobe rather than waiting it out.
                if (HlsPixTh_tvalid) begin
                    state_d = ST_BUSY;
                    lat_clr = 1'b1;
                    lat_inc = 1'b1;
                end else if (pulse_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    pulse_d = pulse_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_BUSY:   code_d = UO_BUSY;
            ST_RESULT: code_d = UO_RESULT;
            default:   code_d = UO_IDLE;
        endcase
        busy_d = (state_d == ST_BUSY);
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_q   <= ST_IDLE;
            pulse_q   <= '0;
            class_q   <= '0;
            code_q    <= UO_IDLE;
            busy_q    <= 1'b0;
            latency_q <= '0;
            lat_vld_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pulse_q   <= pulse_d;
            class_q   <= class_d;
            code_q    <= code_d;
            busy_q    <= busy_d;
            latency_q <= latency_d;
            lat_vld_q <= lat_vld_d;
            timeout_q <= timeout_d;
        end
    end

    assign UserOutput  = {class_q, code_q};
    assign busy        = busy_q;
    assign latency     = latency_q;
    assign latency_vld = lat_vld_q;
    assign timeout_err = timeout_q;

`ifdef LATENCY_STATS_EN
    logic [LAT_W-1:0] lat_max_q, lat_max_d;
    logic [31:0]      done_cnt_q, done_cnt_d;

    always_comb begin
        lat_max_d  = lat_max_q;
        done_cnt_d = done_cnt_q;
        if (lat_vld_d) begin
            done_cnt_d = done_cnt_q + 32'd1;
            if (lat_cnt > lat_max_q) begin
                lat_max_d = lat_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            lat_max_q  <= '0;
            done_cnt_q <= '0;
        end else begin
            lat_max_q  <= lat_max_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign lat_max  = lat_max_q;
    assign done_cnt = done_cnt_q;
`endif

endmodule
